draw_sequencer: RTL and testbench

- Top-level scheduler that owns the single VGA adapter write port and shares it between the screen-fill engine and the circle engine.
- On one `start` request it runs an optional full-screen clear, then one circle draw.
- It drives each engine's level start/done handshake, latches the circle parameters, and muxes and clips pixel writes into one registered VGA plot stream.

---
 rtl/draw_pkg.sv | 30 +++
 rtl/plot_mux_clip.sv | 58 +++++
 rtl/draw_sequencer.sv | 131 +++++++++++++
 tb/tb_draw_sequencer.sv | 283 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/draw_pkg.sv
// Shared types and screen constants for the draw sequencer and its plot path.
// The pixel struct is the common currency between engines and the plot mux.
package draw_pkg;

    localparam int unsigned SCREEN_W = 160;
    localparam int unsigned SCREEN_H = 120;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FILL,
        S_FILL_REL,
        S_CIRC,
        S_CIRC_REL,
        S_DONE
    } state_t;

    typedef enum logic [1:0] {
        SRC_NONE,
        SRC_FILL,
        SRC_CIRC
    } src_t;

    typedef struct packed {
        logic [7:0] x;
        logic [6:0] y;
        logic [2:0] colour;
        logic       plot;
    } pixel_t;

endpackage

// File: rtl/plot_mux_clip.sv
// Selects one engine's pixel stream, drops off-screen points and registers the
// result onto the VGA write port.
module plot_mux_clip #(
    parameter int unsigned SCREEN_W = draw_pkg::SCREEN_W,
    parameter int unsigned SCREEN_H = draw_pkg::SCREEN_H
) (
    input  logic              clk,
    input  logic              rst,
    input  draw_pkg::src_t    sel,
    input  draw_pkg::pixel_t  fill_pix,
    input  draw_pkg::pixel_t  circ_pix,
    output logic [7:0]        vga_x,
    output logic [6:0]        vga_y,
    output logic [2:0]        vga_colour,
    output logic              vga_plot
);
    import draw_pkg::*;

    pixel_t src;
    logic   in_state;
    logic   on_screen;

    always_comb begin
        src      = '0;
        in_state = 1'b0;
        case (sel)
            SRC_FILL: begin
                src      = fill_pix;
                in_state = 1'b1;
            end
            SRC_CIRC: begin
                src      = circ_pix;
                in_state = 1'b1;
            end
            default: ;
        endcase
    end

    // Unsigned full-width compares so engine wrap-around (x=255, y=127) is dropped.
    assign on_screen = (32'(src.x) < SCREEN_W) && (32'(src.y) < SCREEN_H);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vga_x      <= '0;
            vga_y      <= '0;
            vga_colour <= '0;
            vga_plot   <= 1'b0;
        end else begin
            vga_plot <= src.plot & in_state & on_screen;
            if (in_state) begin
                vga_x      <= src.x;
                vga_y      <= src.y;
                vga_colour <= src.colour;
            end
        end
    end

endmodule

// File: rtl/draw_sequencer.sv
// Job scheduler: optional screen clear followed by one circle, sharing the
// single VGA write port between the fill and circle engines.
module draw_sequencer #(
    parameter logic [2:0]  CLEAR_COLOUR = 3'b000,
    parameter int unsigned SCREEN_W     = draw_pkg::SCREEN_W,
    parameter int unsigned SCREEN_H     = draw_pkg::SCREEN_H
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       skip_fill,
    input  logic [7:0] centre_x,
    input  logic [6:0] centre_y,
    input  logic [7:0] radius,
    input  logic [2:0] colour,
    output logic       done,
    output logic       fill_start,
    output logic [2:0] fill_colour,
    input  logic       fill_done,
    input  logic [7:0] fill_x,
    input  logic [6:0] fill_y,
    input  logic       fill_plot,
    output logic       circ_start,
    output logic [7:0] circ_cx,
    output logic [6:0] circ_cy,
    output logic [7:0] circ_r,
    output logic [2:0] circ_colour,
    input  logic       circ_done,
    input  logic [7:0] circ_x,
    input  logic [6:0] circ_y,
    input  logic       circ_plot,
    output logic [7:0] vga_x,
    output logic [6:0] vga_y,
    output logic [2:0] vga_colour,
    output logic       vga_plot
);
    import draw_pkg::*;

    state_t state, state_next;
    src_t   sel;
    logic   accept;
    pixel_t fill_pix;
    pixel_t circ_pix;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Dropping start in any active state abandons the job; the IDLE guard then
    // holds off a restart until both engines have released their done lines.
    always_comb begin
        state_next = state;
        accept     = 1'b0;
        done       = 1'b0;
        fill_start = 1'b0;
        circ_start = 1'b0;
        sel        = SRC_NONE;
        case (state)
            S_IDLE: begin
                if (start && !fill_done && !circ_done) begin
                    accept     = 1'b1;
                    state_next = skip_fill ? S_CIRC : S_FILL;
                end
            end
            S_FILL: begin
                fill_start = 1'b1;
                sel        = SRC_FILL;
                if (!start)         state_next = S_IDLE;
                else if (fill_done) state_next = S_FILL_REL;
            end
            S_FILL_REL: begin
                if (!start)          state_next = S_IDLE;
                else if (!fill_done) state_next = S_CIRC;
            end
            S_CIRC: begin
                circ_start = 1'b1;
                sel        = SRC_CIRC;
                if (!start)         state_next = S_IDLE;
                else if (circ_done) state_next = S_CIRC_REL;
            end
            S_CIRC_REL: begin
                if (!start)          state_next = S_IDLE;
                else if (!circ_done) state_next = S_DONE;
            end
            S_DONE: begin
                done = 1'b1;
                if (!start) state_next = S_IDLE;
            end
            default: state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            circ_cx     <= '0;
            circ_cy     <= '0;
            circ_r      <= '0;
            circ_colour <= '0;
        end else if (accept) begin
            circ_cx     <= centre_x;
            circ_cy     <= centre_y;
            circ_r      <= radius;
            circ_colour <= colour;
        end
    end

    assign fill_colour = CLEAR_COLOUR;

    assign fill_pix = '{x: fill_x, y: fill_y, colour: CLEAR_COLOUR, plot: fill_plot};
    assign circ_pix = '{x: circ_x, y: circ_y, colour: circ_colour, plot: circ_plot};

    plot_mux_clip #(
        .SCREEN_W (SCREEN_W),
        .SCREEN_H (SCREEN_H)
    ) u_plot (
        .clk        (clk),
        .rst        (rst),
        .sel        (sel),
        .fill_pix   (fill_pix),
        .circ_pix   (circ_pix),
        .vga_x      (vga_x),
        .vga_y      (vga_y),
        .vga_colour (vga_colour),
        .vga_plot   (vga_plot)
    );

endmodule

// File: tb/tb_draw_sequencer.sv
// Directed bench for draw_sequencer: engine done lines are driven by hand,
// clip behaviour is table-driven, handshake corners are hand-written sequences.
module tb_draw_sequencer;

    logic       clk;
    logic       rst;
    logic       start;
    logic       skip_fill;
    logic [7:0] centre_x;
    logic [6:0] centre_y;
    logic [7:0] radius;
    logic [2:0] colour;
    logic       done;
    logic       fill_start;
    logic [2:0] fill_colour;
    logic       fill_done;
    logic [7:0] fill_x;
    logic [6:0] fill_y;
    logic       fill_plot;
    logic       circ_start;
    logic [7:0] circ_cx;
    logic [6:0] circ_cy;
    logic [7:0] circ_r;
    logic [2:0] circ_colour;
    logic       circ_done;
    logic [7:0] circ_x;
    logic [6:0] circ_y;
    logic       circ_plot;
    logic [7:0] vga_x;
    logic [6:0] vga_y;
    logic [2:0] vga_colour;
    logic       vga_plot;

    int total_count;
    int bad_count;

    typedef struct {
        logic [7:0] x;
        logic [6:0] y;
        logic       plot;
        logic       exp_plot;
    } clip_vec_t;

    clip_vec_t vecs [7];

    draw_sequencer #(
        .CLEAR_COLOUR (3'b000),
        .SCREEN_W     (160),
        .SCREEN_H     (120)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .skip_fill   (skip_fill),
        .centre_x    (centre_x),
        .centre_y    (centre_y),
        .radius      (radius),
        .colour      (colour),
        .done        (done),
        .fill_start  (fill_start),
        .fill_colour (fill_colour),
        .fill_done   (fill_done),
        .fill_x      (fill_x),
        .fill_y      (fill_y),
        .fill_plot   (fill_plot),
        .circ_start  (circ_start),
        .circ_cx     (circ_cx),
        .circ_cy     (circ_cy),
        .circ_r      (circ_r),
        .circ_colour (circ_colour),
        .circ_done   (circ_done),
        .circ_x      (circ_x),
        .circ_y      (circ_y),
        .circ_plot   (circ_plot),
        .vga_x       (vga_x),
        .vga_y       (vga_y),
        .vga_colour  (vga_colour),
        .vga_plot    (vga_plot)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_count++;
        if (act !== exp) begin
            bad_count++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic applyStimulus(input clip_vec_t v);
        circ_x    = v.x;
        circ_y    = v.y;
        circ_plot = v.plot;
        tick();
    endtask

    initial begin
        vecs[0] = '{x: 8'd159, y: 7'd119, plot: 1'b1, exp_plot: 1'b1};
        vecs[1] = '{x: 8'd160, y: 7'd5,   plot: 1'b1, exp_plot: 1'b0};
        vecs[2] = '{x: 8'd5,   y: 7'd120, plot: 1'b1, exp_plot: 1'b0};
        vecs[3] = '{x: 8'd255, y: 7'd127, plot: 1'b1, exp_plot: 1'b0};
        vecs[4] = '{x: 8'd0,   y: 7'd0,   plot: 1'b1, exp_plot: 1'b1};
        vecs[5] = '{x: 8'd100, y: 7'd50,  plot: 1'b0, exp_plot: 1'b0};
        vecs[6] = '{x: 8'd159, y: 7'd0,   plot: 1'b1, exp_plot: 1'b1};

        total_count = 0;
        bad_count   = 0;
        rst       = 1'b1;
        start     = 1'b0;
        skip_fill = 1'b0;
        centre_x  = 8'd0;
        centre_y  = 7'd0;
        radius    = 8'd0;
        colour    = 3'd0;
        fill_done = 1'b0;
        fill_x    = 8'd0;
        fill_y    = 7'd0;
        fill_plot = 1'b0;
        circ_done = 1'b0;
        circ_x    = 8'd0;
        circ_y    = 7'd0;
        circ_plot = 1'b0;

        #3;
        checkOutput("reset_done", done, 0);
        checkOutput("reset_fill_start", fill_start, 0);
        checkOutput("reset_circ_start", circ_start, 0);
        checkOutput("reset_vga_plot", vga_plot, 0);
        checkOutput("reset_vga_x", vga_x, 0);
        checkOutput("reset_circ_r", circ_r, 0);
        checkOutput("fill_colour_const", fill_colour, 0);
        tick();
        rst = 1'b0;
        tick();

        // Full job with clear pass.
        $display("[TB] full job");
        start    = 1'b1;
        centre_x = 8'd80;
        centre_y = 7'd60;
        radius   = 8'd40;
        colour   = 3'b010;
        tick();
        checkOutput("job_fill_start", fill_start, 1);
        checkOutput("job_circ_start_low", circ_start, 0);
        checkOutput("job_cx", circ_cx, 80);
        checkOutput("job_cy", circ_cy, 60);
        checkOutput("job_r", circ_r, 40);
        checkOutput("job_colour", circ_colour, 2);
        radius   = 8'd7;
        centre_x = 8'd3;
        fill_x    = 8'd10;
        fill_y    = 7'd20;
        fill_plot = 1'b1;
        tick();
        checkOutput("fill_vga_plot", vga_plot, 1);
        checkOutput("fill_vga_x", vga_x, 10);
        checkOutput("fill_vga_y", vga_y, 20);
        checkOutput("fill_vga_colour", vga_colour, 0);
        checkOutput("fill_start_held", fill_start, 1);
        fill_plot = 1'b0;
        fill_done = 1'b1;
        tick();
        checkOutput("fill_rel_fill_start", fill_start, 0);
        checkOutput("fill_rel_circ_start", circ_start, 0);
        tick();
        checkOutput("fill_rel_wait", circ_start, 0);
        fill_done = 1'b0;
        tick();
        checkOutput("circ_start_up", circ_start, 1);
        checkOutput("circ_fill_start_low", fill_start, 0);
        checkOutput("circ_r_stable", circ_r, 40);
        checkOutput("circ_cx_stable", circ_cx, 80);

        for (int i = 0; i < 7; i++) begin
            applyStimulus(vecs[i]);
            checkOutput($sformatf("clip_plot_%0d", i), vga_plot, vecs[i].exp_plot);
            if (vecs[i].exp_plot) begin
                checkOutput($sformatf("clip_x_%0d", i), vga_x, vecs[i].x);
                checkOutput($sformatf("clip_y_%0d", i), vga_y, vecs[i].y);
                checkOutput($sformatf("clip_colour_%0d", i), vga_colour, 2);
            end
        end
        circ_plot = 1'b0;
        checkOutput("circ_r_end", circ_r, 40);
        circ_done = 1'b1;
        tick();
        checkOutput("circ_rel_start", circ_start, 0);
        checkOutput("circ_rel_done", done, 0);
        circ_done = 1'b0;
        tick();
        checkOutput("job_done", done, 1);
        checkOutput("done_no_plot", vga_plot, 0);
        tick();
        checkOutput("job_done_held", done, 1);
        start = 1'b0;
        tick();
        checkOutput("job_done_drop", done, 0);
        tick();

        // Skip the clear pass.
        $display("[TB] skip fill");
        skip_fill = 1'b1;
        radius    = 8'd12;
        start     = 1'b1;
        tick();
        checkOutput("skip_circ_start", circ_start, 1);
        checkOutput("skip_fill_start", fill_start, 0);
        checkOutput("skip_r", circ_r, 12);
        circ_done = 1'b1;
        tick();
        circ_done = 1'b0;
        tick();
        checkOutput("skip_done", done, 1);
        checkOutput("skip_fill_never", fill_start, 0);
        start = 1'b0;
        tick();
        checkOutput("skip_done_drop", done, 0);

        // Abort mid-fill, then refused restart while fill_done is still high.
        $display("[TB] abort mid-fill");
        skip_fill = 1'b0;
        start     = 1'b1;
        tick();
        checkOutput("abort_fill_start", fill_start, 1);
        start = 1'b0;
        tick();
        checkOutput("abort_fill_drop", fill_start, 0);
        checkOutput("abort_done", done, 0);
        fill_done = 1'b1;
        start     = 1'b1;
        tick();
        checkOutput("refuse_fill", fill_start, 0);
        checkOutput("refuse_circ", circ_start, 0);
        tick();
        checkOutput("refuse_fill_2", fill_start, 0);
        fill_done = 1'b0;
        tick();
        checkOutput("restart_fill", fill_start, 1);
        start = 1'b0;
        tick();
        checkOutput("restart_abort", fill_start, 0);

        // Asynchronous reset in the middle of a circle pass.
        $display("[TB] async reset mid-circ");
        skip_fill = 1'b1;
        start     = 1'b1;
        tick();
        checkOutput("rst_circ_start_pre", circ_start, 1);
        circ_x    = 8'd10;
        circ_y    = 7'd10;
        circ_plot = 1'b1;
        tick();
        checkOutput("rst_vga_plot_pre", vga_plot, 1);
        #2;
        rst = 1'b1;
        #1;
        checkOutput("rst_circ_start", circ_start, 0);
        checkOutput("rst_vga_plot", vga_plot, 0);
        checkOutput("rst_done", done, 0);
        checkOutput("rst_circ_r", circ_r, 0);
        tick();
        start     = 1'b0;
        circ_plot = 1'b0;
        rst       = 1'b0;
        tick();
        checkOutput("post_rst_circ", circ_start, 0);
        checkOutput("post_rst_fill", fill_start, 0);
        checkOutput("post_rst_done", done, 0);
        checkOutput("post_rst_plot", vga_plot, 0);

        $display("test done: total=%0d bad=%0d", total_count, bad_count);
        $finish;
    end

endmodule
